// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------------------------------------------------------------------
// MEM stage of the pipeline. Sits behind the EX/MEM latch and turns the memory
// control bits (Enable, rw, Size, Signed, Load, rf, Rd) into byte, halfword,
// word or doubleword accesses on a single-port, 32-bit, little-endian data
// memory that answers each request beat with a one-cycle Mem_Ack. While an
// access is outstanding the stage holds the upstream pipeline with Stall_Out,
// and when it completes it drives the MEM/WB latch inputs.
//
// Ports
//   CLK, CLR            clock (rising edge), asynchronous active-high reset
//   Enable_In           memory operation valid (0 = ALU result pass-through)
//   rw_In               1 = store, 0 = load
//   Size_In             00 byte, 01 halfword, 10 word, 11 doubleword
//   Signed_In           sign-extend byte/halfword loads
//   Load_In             1 = write back memory data, 0 = write back Address_In
//   rf_In, Rd_In        register-file write enable and destination
//   Address_In          ALU result / effective address
//   StoreData_In        store data (low word)
//   StoreDataHi_In      store data, second word of a doubleword
//   Mem_Req/RW/Addr/WData/ByteEn   memory request bundle (registered)
//   Mem_Ack, Mem_RData  memory completion and read data
//   Stall_Out           hold EX/MEM and earlier stages
//   WB_*_Out            MEM/WB inputs (data, high data, Rd, write enable,
//                       doubleword flag)
//   Fault_Out           one-cycle pulse on misalignment or ack timeout
// ----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Enable_In,
    input  logic        rw_In,
    input  logic [1:0]  Size_In,
    input  logic        Signed_In,
    input  logic        Load_In,
    input  logic        rf_In,
    input  logic [3:0]  Rd_In,
    input  logic [31:0] Address_In,
    input  logic [31:0] StoreData_In,
    input  logic [31:0] StoreDataHi_In,
    output logic        Mem_Req,
    output logic        Mem_RW,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_WData,
    output logic [3:0]  Mem_ByteEn,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        Stall_Out,
    output logic [31:0] WB_Data_Out,
    output logic [31:0] WB_DataHi_Out,
    output logic [3:0]  WB_Rd_Out,
    output logic        WB_rf_Out,
    output logic        WB_Dword_Out,
    output logic        Fault_Out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    // Last counter value of a beat; reaching it without an ack aborts.
    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] ack_cnt;

    // Operands captured when the access is accepted.
    logic        rw_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        load_q;
    logic        rf_q;
    logic [3:0]  rd_q;
    logic [31:0] addr_q;
    logic [31:0] store_hi_q;
    logic [31:0] low_word_q;

    // Registered memory request bundle.
    logic        mem_rw_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_byteen_q;

    // Registered MEM/WB outputs.
    logic [31:0] wb_data_q;
    logic [31:0] wb_data_hi_q;
    logic [3:0]  wb_rd_q;
    logic        wb_rf_q;
    logic        wb_dword_q;
    logic        fault_q;

    logic        aligned;
    logic        start_access;
    logic        in_beat;
    logic        final_ack;
    logic        timeout_hit;
    logic [3:0]  byteen_next;
    logic [31:0] wdata_next;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] wb_value;

    // Natural alignment check of the incoming effective address.
    always_comb begin
        case (Size_In)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~Address_In[0];
            SZ_WORD: aligned = (Address_In[1:0] == 2'b00);
            default: aligned = (Address_In[2:0] == 3'b000);
        endcase
    end

    // Lane enables and lane-replicated write data for the first beat.
    always_comb begin
        case (Size_In)
            SZ_BYTE: begin
                byteen_next = 4'b0001 << Address_In[1:0];
                wdata_next  = {4{StoreData_In[7:0]}};
            end
            SZ_HALF: begin
                byteen_next = Address_In[1] ? 4'b1100 : 4'b0011;
                wdata_next  = {2{StoreData_In[15:0]}};
            end
            default: begin
                byteen_next = 4'b1111;
                wdata_next  = StoreData_In;
            end
        endcase
    end

    // Lane selection and extension of returned read data, using the
    // captured address so the result does not depend on upstream inputs.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = Mem_RData[7:0];
            2'd1:    lane_byte = Mem_RData[15:8];
            2'd2:    lane_byte = Mem_RData[23:16];
            default: lane_byte = Mem_RData[31:24];
        endcase
        lane_half = addr_q[1] ? Mem_RData[31:16] : Mem_RData[15:0];
        case (size_q)
            SZ_BYTE: load_value = {{24{signed_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_value = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_value = Mem_RData;
        endcase
        wb_value = load_q ? load_value : addr_q;
    end

    assign in_beat      = (state == BEAT0) || (state == BEAT1);
    assign start_access = (state == IDLE) && Enable_In && aligned;

    // The ack that ends the whole access: any ack in BEAT1, or a BEAT0 ack
    // for everything but a doubleword.
    assign final_ack   = Mem_Ack && (((state == BEAT0) && (size_q != SZ_DWORD)) ||
                                     (state == BEAT1));
    // An ack on the last count cycle wins, hence the ~Mem_Ack term.
    assign timeout_hit = in_beat && !Mem_Ack && (ack_cnt == CNT_LAST);

    // Stall is released in the cycle that finishes the access so the
    // upstream latch advances on the same edge the stage returns to IDLE.
    // Reset forces it low along with every other output.
    assign Stall_Out = !CLR && (start_access || (in_beat && !final_ack && !timeout_hit));

    assign Mem_Req       = in_beat;
    assign Mem_RW        = mem_rw_q;
    assign Mem_Addr      = mem_addr_q;
    assign Mem_WData     = mem_wdata_q;
    assign Mem_ByteEn    = mem_byteen_q;
    assign WB_Data_Out   = wb_data_q;
    assign WB_DataHi_Out = wb_data_hi_q;
    assign WB_Rd_Out     = wb_rd_q;
    assign WB_rf_Out     = wb_rf_q;
    assign WB_Dword_Out  = wb_dword_q;
    assign Fault_Out     = fault_q;

    // Access sequencer. WB outputs only change on completion or pass-through;
    // every other edge holds them but forces the write enable low so a
    // stalled or aborted instruction never produces a register write.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state        <= IDLE;
            ack_cnt      <= '0;
            rw_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            load_q       <= 1'b0;
            rf_q         <= 1'b0;
            rd_q         <= '0;
            addr_q       <= '0;
            store_hi_q   <= '0;
            low_word_q   <= '0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
            wb_data_q    <= '0;
            wb_data_hi_q <= '0;
            wb_rd_q      <= '0;
            wb_rf_q      <= 1'b0;
            wb_dword_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!Enable_In) begin
                        wb_data_q  <= Address_In;
                        wb_rd_q    <= Rd_In;
                        wb_rf_q    <= rf_In;
                        wb_dword_q <= 1'b0;
                    end else if (!aligned) begin
                        fault_q <= 1'b1;
                        wb_rf_q <= 1'b0;
                    end else begin
                        wb_rf_q      <= 1'b0;
                        state        <= BEAT0;
                        ack_cnt      <= '0;
                        rw_q         <= rw_In;
                        size_q       <= Size_In;
                        signed_q     <= Signed_In;
                        load_q       <= Load_In;
                        rf_q         <= rf_In;
                        rd_q         <= Rd_In;
                        addr_q       <= Address_In;
                        store_hi_q   <= StoreDataHi_In;
                        mem_rw_q     <= rw_In;
                        mem_addr_q   <= {Address_In[31:2], 2'b00};
                        mem_wdata_q  <= wdata_next;
                        mem_byteen_q <= byteen_next;
                    end
                end

                BEAT0: begin
                    if (Mem_Ack) begin
                        if (size_q == SZ_DWORD) begin
                            low_word_q  <= Mem_RData;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_wdata_q <= store_hi_q;
                            ack_cnt     <= '0;
                            wb_rf_q     <= 1'b0;
                            state       <= BEAT1;
                        end else begin
                            wb_data_q  <= wb_value;
                            wb_rd_q    <= rd_q;
                            wb_rf_q    <= rf_q & ~rw_q;
                            wb_dword_q <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        wb_rf_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                        wb_rf_q <= 1'b0;
                    end
                end

                BEAT1: begin
                    if (Mem_Ack) begin
                        wb_data_q    <= load_q ? low_word_q : addr_q;
                        wb_data_hi_q <= Mem_RData;
                        wb_rd_q      <= rd_q;
                        wb_rf_q      <= rf_q & ~rw_q;
                        wb_dword_q   <= 1'b1;
                        state        <= IDLE;
                    end else if (timeout_hit) begin
                        fault_q <= 1'b1;
                        wb_rf_q <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                        wb_rf_q <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    wb_rf_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        Enable_In = 1'b0;
    logic        rw_In = 1'b0;
    logic [1:0]  Size_In = 2'b00;
    logic        Signed_In = 1'b0;
    logic        Load_In = 1'b0;
    logic        rf_In = 1'b0;
    logic [3:0]  Rd_In = 4'd0;
    logic [31:0] Address_In = 32'd0;
    logic [31:0] StoreData_In = 32'd0;
    logic [31:0] StoreDataHi_In = 32'd0;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_RData = 32'd0;
    logic        Mem_Req;
    logic        Mem_RW;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_ByteEn;
    logic        Stall_Out;
    logic [31:0] WB_Data_Out;
    logic [31:0] WB_DataHi_Out;
    logic [3:0]  WB_Rd_Out;
    logic        WB_rf_Out;
    logic        WB_Dword_Out;
    logic        Fault_Out;

    always #5 CLK = ~CLK;

    mem_access_stage #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .CLR(CLR),
        .Enable_In(Enable_In), .rw_In(rw_In), .Size_In(Size_In),
        .Signed_In(Signed_In), .Load_In(Load_In), .rf_In(rf_In), .Rd_In(Rd_In),
        .Address_In(Address_In), .StoreData_In(StoreData_In),
        .StoreDataHi_In(StoreDataHi_In),
        .Mem_Req(Mem_Req), .Mem_RW(Mem_RW), .Mem_Addr(Mem_Addr),
        .Mem_WData(Mem_WData), .Mem_ByteEn(Mem_ByteEn),
        .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
        .Stall_Out(Stall_Out),
        .WB_Data_Out(WB_Data_Out), .WB_DataHi_Out(WB_DataHi_Out),
        .WB_Rd_Out(WB_Rd_Out), .WB_rf_Out(WB_rf_Out),
        .WB_Dword_Out(WB_Dword_Out), .Fault_Out(Fault_Out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the registered MEM/WB outputs.
    logic [31:0] mWbData = 32'd0;
    logic [31:0] mWbHi = 32'd0;
    logic [3:0]  mWbRd = 4'd0;
    logic        mWbRf = 1'b0;
    logic        mWbDword = 1'b0;
    logic        mFault = 1'b0;
    bit          careData = 1'b1;
    bit          careHi = 1'b1;
    bit          careDword = 1'b1;

    // Expectations for the current cycle.
    bit          expValid = 1'b0;
    logic        expStall = 1'b0;
    logic        expReq = 1'b0;
    logic        expRw = 1'b0;
    logic [31:0] expAddr = 32'd0;
    logic [31:0] expWData = 32'd0;
    logic [3:0]  expByteEn = 4'd0;

    // Observations of the most recent operation.
    int          obsStall;
    int          obsReq;
    logic [31:0] obsAddr0, obsAddr1, obsWData;
    logic [3:0]  obsByteEn;
    logic        obsRw;
    logic [31:0] entryWbData, entryWbHi;
    logic [3:0]  entryWbRd;
    logic        entryWbRf, entryWbDword, entryFault;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic bit isAligned(input logic [31:0] addr, input logic [1:0] sz);
        return (addr % (32'd1 << sz)) == 32'd0;
    endfunction

    function automatic logic [3:0] byteEnOf(input logic [1:0] sz, input logic [31:0] addr);
        int unsigned nb;
        nb = 32'd1 << sz;
        if (nb >= 4) return 4'hF;
        return 4'(((32'd1 << nb) - 32'd1) << (addr % 32'd4));
    endfunction

    function automatic logic [31:0] wdataOf(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return 32'(sd[7:0]) * 32'h01010101;
        if (sz == 2'd1) return 32'(sd[15:0]) * 32'h00010001;
        return sd;
    endfunction

    function automatic logic [31:0] extractLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                                input logic [1:0] sz, input logic sgn);
        int unsigned v;
        if (sz == 2'd0) begin
            v = (rdata >> (8 * int'(addr[1:0]))) % 32'd256;
            if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (rdata >> (16 * int'(addr[1]))) % 32'd65536;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Compares every output against the model in the middle of each cycle.
    always @(negedge CLK) begin
        if (expValid && !CLR) begin
            checkOutput("Mem_Req", 32'(Mem_Req), 32'(expReq));
            if (expReq) begin
                checkOutput("Mem_RW", 32'(Mem_RW), 32'(expRw));
                checkOutput("Mem_Addr", Mem_Addr, expAddr);
                checkOutput("Mem_WData", Mem_WData, expWData);
                checkOutput("Mem_ByteEn", 32'(Mem_ByteEn), 32'(expByteEn));
            end
            checkOutput("Stall_Out", 32'(Stall_Out), 32'(expStall));
            checkOutput("Fault_Out", 32'(Fault_Out), 32'(mFault));
            checkOutput("WB_rf_Out", 32'(WB_rf_Out), 32'(mWbRf));
            checkOutput("WB_Rd_Out", 32'(WB_Rd_Out), 32'(mWbRd));
            if (careData)  checkOutput("WB_Data_Out", WB_Data_Out, mWbData);
            if (careHi)    checkOutput("WB_DataHi_Out", WB_DataHi_Out, mWbHi);
            if (careDword) checkOutput("WB_Dword_Out", 32'(WB_Dword_Out), 32'(mWbDword));
        end
    end

    // Runs one instruction from its IDLE cycle to completion, playing the
    // memory (ack after 'lat' waiting cycles per beat; lat >= TIMEOUT never
    // acks) and advancing the model at each edge. Returns right at an edge.
    task automatic applyStimulus(input logic en, input logic rw, input logic [1:0] sz,
                                 input logic sgn, input logic ld, input logic rf,
                                 input logic [3:0] dst, input logic [31:0] addr,
                                 input logic [31:0] sd, input logic [31:0] sdh,
                                 input logic [31:0] rdata0, input logic [31:0] rdata1,
                                 input int lat0, input int lat1);
        int beats;
        int lat;
        bit ok;
        logic ack;
        obsStall = 0;
        obsReq = 0;
        #1;
        Enable_In = en; rw_In = rw; Size_In = sz; Signed_In = sgn; Load_In = ld;
        rf_In = rf; Rd_In = dst; Address_In = addr; StoreData_In = sd;
        StoreDataHi_In = sdh;
        Mem_Ack = 1'($urandom_range(0, 1));
        Mem_RData = $urandom;
        ok = isAligned(addr, sz);
        expValid = 1'b1;
        expReq = 1'b0;
        expStall = en && ok;
        @(negedge CLK);
        entryWbData = WB_Data_Out; entryWbHi = WB_DataHi_Out; entryWbRd = WB_Rd_Out;
        entryWbRf = WB_rf_Out; entryWbDword = WB_Dword_Out; entryFault = Fault_Out;
        if (Stall_Out) obsStall++;
        @(posedge CLK);
        mFault = 1'b0;
        if (!en) begin
            mWbData = addr; mWbRd = dst; mWbRf = rf; mWbDword = 1'b0;
            careData = 1'b1; careDword = 1'b1;
            return;
        end
        if (!ok) begin
            mFault = 1'b1; mWbRf = 1'b0;
            return;
        end
        mWbRf = 1'b0;
        beats = (sz == 2'd3) ? 2 : 1;
        for (int b = 0; b < beats; b++) begin
            lat = (b == 0) ? lat0 : lat1;
            for (int i = 0; i < TIMEOUT; i++) begin
                #1;
                ack = (i == lat);
                Mem_Ack = ack;
                Mem_RData = ack ? ((b == 0) ? rdata0 : rdata1) : $urandom;
                expReq = 1'b1;
                expRw = rw;
                expAddr = {addr[31:2], 2'b00} + 32'(4 * b);
                expByteEn = byteEnOf(sz, addr);
                expWData = (b == 0) ? wdataOf(sz, sd) : sdh;
                expStall = !(ack && b == beats - 1) && !(!ack && i == TIMEOUT - 1);
                @(negedge CLK);
                if (Stall_Out) obsStall++;
                if (Mem_Req) obsReq++;
                if (i == 0 && b == 0) begin
                    obsAddr0 = Mem_Addr; obsByteEn = Mem_ByteEn;
                    obsWData = Mem_WData; obsRw = Mem_RW;
                end
                if (i == 0 && b == 1) obsAddr1 = Mem_Addr;
                @(posedge CLK);
                mFault = 1'b0;
                if (ack) begin
                    if (b == beats - 1) begin
                        mWbRd = dst;
                        mWbRf = rf && !rw;
                        if (rw) begin
                            careData = 1'b0; careHi = 1'b0; careDword = 1'b0;
                        end else if (beats == 2) begin
                            mWbData = ld ? rdata0 : addr;
                            mWbHi = rdata1; mWbDword = 1'b1;
                            careData = 1'b1; careHi = 1'b1; careDword = 1'b1;
                        end else begin
                            mWbData = ld ? extractLoad(rdata0, addr, sz, sgn) : addr;
                            mWbDword = 1'b0;
                            careData = 1'b1; careDword = 1'b1;
                        end
                        return;
                    end
                    mWbRf = 1'b0;
                    break;
                end else if (i == TIMEOUT - 1) begin
                    mFault = 1'b1;
                    mWbRf = 1'b0;
                    return;
                end else begin
                    mWbRf = 1'b0;
                end
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0,
                      32'd0, 32'd0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic resetModel();
        mWbData = 32'd0; mWbHi = 32'd0; mWbRd = 4'd0; mWbRf = 1'b0;
        mWbDword = 1'b0; mFault = 1'b0;
        careData = 1'b1; careHi = 1'b1; careDword = 1'b1;
    endtask

    initial begin
        logic        en, rw, sgn, ld, rf;
        logic [1:0]  sz;
        logic [3:0]  dst;
        logic [31:0] addr;
        int          lat0, lat1;

        // Reset state, with an aligned access presented so stall gating is visible.
        Enable_In = 1'b1; Size_In = 2'd2; Address_In = 32'h100;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset Mem_Req", 32'(Mem_Req), 32'd0);
        checkOutput("reset Stall_Out", 32'(Stall_Out), 32'd0);
        checkOutput("reset WB_Data_Out", WB_Data_Out, 32'd0);
        checkOutput("reset WB_rf_Out", 32'(WB_rf_Out), 32'd0);
        checkOutput("reset Fault_Out", 32'(Fault_Out), 32'd0);
        Enable_In = 1'b0; Size_In = 2'd0; Address_In = 32'd0;
        CLR = 1'b0;
        resetModel();

        // Word load at 0x104, ack one cycle after the request.
        applyStimulus(1, 0, 2'd2, 0, 1, 1, 4'd3, 32'h104, 32'd0, 32'd0,
                      32'hDEADBEEF, 32'd0, 1, 0);
        checkOutput("word Mem_Addr", obsAddr0, 32'h104);
        checkOutput("word ByteEn", 32'(obsByteEn), 32'hF);
        checkOutput("word stall cycles", obsStall, 2);
        idleCycle();
        checkOutput("word WB_Data", entryWbData, 32'hDEADBEEF);
        checkOutput("word WB_Rd", 32'(entryWbRd), 32'd3);
        checkOutput("word WB_rf", 32'(entryWbRf), 32'd1);

        // Signed and unsigned byte loads from lane 3.
        applyStimulus(1, 0, 2'd0, 1, 1, 1, 4'd4, 32'h103, 32'd0, 32'd0,
                      32'h80FF1234, 32'd0, 0, 0);
        checkOutput("sbyte ByteEn", 32'(obsByteEn), 32'h8);
        idleCycle();
        checkOutput("sbyte WB_Data", entryWbData, 32'hFFFFFF80);
        applyStimulus(1, 0, 2'd0, 0, 1, 1, 4'd4, 32'h103, 32'd0, 32'd0,
                      32'h80FF1234, 32'd0, 0, 0);
        idleCycle();
        checkOutput("ubyte WB_Data", entryWbData, 32'h00000080);

        // Halfword store to the upper half of a word.
        applyStimulus(1, 1, 2'd1, 0, 1, 1, 4'd6, 32'h202, 32'hABCD1234, 32'd0,
                      32'h0, 32'd0, 2, 0);
        checkOutput("hstore Mem_Addr", obsAddr0, 32'h200);
        checkOutput("hstore ByteEn", 32'(obsByteEn), 32'hC);
        checkOutput("hstore WData", obsWData, 32'h12341234);
        checkOutput("hstore RW", 32'(obsRw), 32'd1);
        idleCycle();
        checkOutput("hstore WB_rf", 32'(entryWbRf), 32'd0);

        // Doubleword load followed by a misaligned word load.
        applyStimulus(1, 0, 2'd3, 0, 1, 1, 4'd8, 32'h300, 32'd0, 32'd0,
                      32'h11111111, 32'h22222222, 0, 1);
        checkOutput("dword second Mem_Addr", obsAddr1, 32'h304);
        applyStimulus(1, 0, 2'd2, 0, 1, 1, 4'd9, 32'h302, 32'd0, 32'd0,
                      32'h0, 32'd0, 0, 0);
        checkOutput("dword WB_Data", entryWbData, 32'h11111111);
        checkOutput("dword WB_DataHi", entryWbHi, 32'h22222222);
        checkOutput("dword WB_Dword", 32'(entryWbDword), 32'd1);
        checkOutput("misaligned Mem_Req cycles", obsReq, 0);
        idleCycle();
        checkOutput("misaligned Fault", 32'(entryFault), 32'd1);
        checkOutput("misaligned WB_rf", 32'(entryWbRf), 32'd0);

        // Timeout with no ack, then a back-to-back ALU op.
        applyStimulus(1, 0, 2'd2, 0, 1, 1, 4'd10, 32'h400, 32'd0, 32'd0,
                      32'h0, 32'd0, 99, 99);
        checkOutput("timeout Mem_Req cycles", obsReq, TIMEOUT);
        checkOutput("timeout stall cycles", obsStall, TIMEOUT);
        applyStimulus(0, 0, 2'd0, 0, 0, 1, 4'd5, 32'h12345678, 32'd0, 32'd0,
                      32'h0, 32'd0, 0, 0);
        checkOutput("timeout Fault", 32'(entryFault), 32'd1);
        checkOutput("timeout WB_rf", 32'(entryWbRf), 32'd0);
        idleCycle();
        checkOutput("alu WB_Data", entryWbData, 32'h12345678);
        checkOutput("alu WB_Rd", 32'(entryWbRd), 32'd5);
        checkOutput("alu WB_rf", 32'(entryWbRf), 32'd1);

        // Ack on the last count cycle wins over the timeout.
        applyStimulus(1, 0, 2'd2, 0, 1, 1, 4'd11, 32'h408, 32'd0, 32'd0,
                      32'hCAFEF00D, 32'd0, TIMEOUT - 1, 0);
        idleCycle();
        checkOutput("late ack Fault", 32'(entryFault), 32'd0);
        checkOutput("late ack WB_Data", entryWbData, 32'hCAFEF00D);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 4) != 0);
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            rf = 1'($urandom_range(0, 1));
            dst = 4'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 5) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            lat0 = $urandom_range(0, TIMEOUT);
            lat1 = $urandom_range(0, TIMEOUT);
            applyStimulus(en, rw, sz, sgn, ld, rf, dst, addr, $urandom, $urandom,
                          $urandom, $urandom, lat0, lat1);
        end

        // Asynchronous reset in the middle of BEAT0.
        #1;
        expValid = 1'b0;
        Enable_In = 1'b1; rw_In = 1'b0; Size_In = 2'd2; Load_In = 1'b1;
        rf_In = 1'b1; Rd_In = 4'd7; Address_In = 32'h500; Mem_Ack = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("mid-beat Mem_Req", 32'(Mem_Req), 32'd1);
        #2;
        CLR = 1'b1;
        Enable_In = 1'b0; rf_In = 1'b0; Rd_In = 4'd0; Address_In = 32'd0;
        #1;
        checkOutput("async reset Mem_Req", 32'(Mem_Req), 32'd0);
        checkOutput("async reset Stall_Out", 32'(Stall_Out), 32'd0);
        checkOutput("async reset Mem_Addr", Mem_Addr, 32'd0);
        checkOutput("async reset WB_Data", WB_Data_Out, 32'd0);
        checkOutput("async reset WB_rf", 32'(WB_rf_Out), 32'd0);
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        resetModel();
        idleCycle();
        idleCycle();
        checkOutput("post-reset WB_rf", 32'(entryWbRf), 32'd0);
        checkOutput("post-reset Fault", 32'(entryFault), 32'd0);

        #1;
        expValid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM stage of the pipeline, directly downstream of the EX/MEM latch that carries the memory control bits (Enable, rw, Size, Load, rf, Rd) produced at ID/EX.
- Performs byte, halfword, word and doubleword loads/stores against a single-port, word-wide, little-endian data memory using a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Drives the MEM/WB inputs: writeback data, Rd, register-file write enable.

Parameters:
ACK_TIMEOUT, 255, max cycles per beat waiting for Mem_Ack before abort (1..65535)

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  reset, asynchronous, active-high
Enable_In  in  1  memory operation valid
rw_In  in  1  1=store, 0=load
Size_In  in  2  00 byte, 01 halfword, 10 word, 11 doubleword
Signed_In  in  1  sign-extend byte/halfword loads
Load_In  in  1  1=writeback memory data, 0=writeback Address_In (ALU result)
rf_In  in  1  register-file write enable for this instruction
Rd_In  in  4  destination register
Address_In  in  32  ALU result / effective address
StoreData_In  in  32  store data (low word)
StoreDataHi_In  in  32  store data, second word of doubleword
Mem_Req  out  1  memory request
Mem_RW  out  1  1=write
Mem_Addr  out  32  word-aligned address (bits[1:0]=00)
Mem_WData  out  32  write data, lane-replicated
Mem_ByteEn  out  4  byte-lane enables
Mem_Ack  in  1  memory completion, one cycle per beat
Mem_RData  in  32  read data, valid with Mem_Ack
Stall_Out  out  1  hold EX/MEM and earlier stages
WB_Data_Out  out  32  writeback data
WB_DataHi_Out  out  32  second word of doubleword load (for Rd+1)
WB_Rd_Out  out  4  destination register
WB_rf_Out  out  1  register write enable
WB_Dword_Out  out  1  WB_DataHi_Out valid
Fault_Out  out  1  one-cycle pulse: misalignment or timeout

Behaviour:
- Reset: CLR asynchronous. State=IDLE, counter=0, all outputs 0. Mem_Req drops in the same instant. Any in-flight access is discarded with no WB write.
- FSM states: IDLE, BEAT0, BEAT1.
- Mem_Req=1 exactly in BEAT0/BEAT1, decoded from state.
- Mem_Addr, Mem_WData, Mem_ByteEn and Mem_RW are registered and stable throughout the beat.
- Non-memory op (IDLE, Enable_In=0): one-cycle pass-through. Next edge: WB_Data_Out=Address_In, WB_Rd_Out=Rd_In, WB_rf_Out=rf_In, WB_Dword_Out=0. Stall_Out=0.
- Alignment rules: halfword needs Address_In[0]=0; word needs [1:0]=0; doubleword needs [2:0]=0.
- Misaligned access: no request issued. Next edge: Fault_Out=1 for one cycle, WB_rf_Out=0. Stall_Out=0.
- Aligned access in IDLE:
  - Stall_Out=1 combinationally.
  - Next edge: latch operands and go to BEAT0, with Mem_Addr={Address_In[31:2],2'b00}.
- Byte enables:
  - byte: 1<<addr[1:0]
  - halfword: 0011 or 1100
  - word/dword: 1111
- Store data: byte replicated ×4; halfword replicated ×2; word as-is.
- Load extraction: select the lane(s) by addr[1:0], then zero- or sign-extend per Signed_In.
- Load_In=0 with a load: the memory data is discarded and WB_Data_Out=Address_In.
- BEAT0 with Mem_Ack:
  - Non-dword: next edge go to IDLE and write the WB outputs (WB_rf_Out=rf_In & ~rw). Stall_Out=0 in this ack cycle, so the upstream latch advances on the same edge.
  - Dword: capture the low word and go to BEAT1 with Mem_Addr+4 and WData=StoreDataHi. Stall_Out stays 1.
- BEAT1 with Mem_Ack: WB_Data_Out=low word, WB_DataHi_Out=Mem_RData, WB_Dword_Out=1. Go to IDLE. Stall_Out=0 in the ack cycle.
- Stall_Out=1 in BEAT0/BEAT1 except the final-ack cycle.
- Mem_Ack outside BEAT0/BEAT1 is ignored.
- Timeout:
  - The counter clears on entering each beat and increments each beat cycle without ack.
  - If the counter reaches ACK_TIMEOUT-1 with no ack: next edge go to IDLE, Fault_Out pulse, WB_rf_Out=0, Stall_Out=0 in that cycle.
  - An ack on the final count cycle wins over the timeout.
- WB outputs hold their last value while stalled, except WB_rf_Out=0 on every stall edge, so no bubble writes.
- Upstream holds all _In signals stable while Stall_Out=1; this is an upstream obligation.

Test Plan:
- Reset mid-BEAT0 (Mem_Req=1), assert CLR asynchronously -> Mem_Req=0 immediately, all outputs 0, no WB write after release.
- Word load from 0x00000104, Mem_Ack one cycle after Mem_Req with RData=0xDEADBEEF, Rd=3, rf=1 -> Mem_Addr=0x104, ByteEn=1111, Stall high 2 cycles, then WB_Data=0xDEADBEEF, WB_Rd=3, WB_rf=1.
- Signed byte load at 0x103, RData=0x80FF1234 -> ByteEn=1000, WB_Data=0xFFFFFF80; unsigned gives 0x00000080.
- Halfword store 0xABCD1234 at 0x202 -> Mem_Addr=0x200, ByteEn=1100, WData=0x12341234, RW=1, WB_rf=0.
- Doubleword load at 0x300, acks RData 0x11111111 then 0x22222222 -> second Mem_Addr=0x304, WB_Data=0x11111111, WB_DataHi=0x22222222, WB_Dword=1. Word load at 0x302 -> Fault pulse, no Mem_Req.
- ACK_TIMEOUT=4, never ack -> Mem_Req high exactly 4 cycles, Fault pulse, Stall drops, WB_rf=0. Back-to-back ALU op follows with one-cycle pass-through.
